// File: rtl/ok_pipe_out_fifo.sv
// Pipe-out endpoint: buffers device-side 16-bit words in a FWFT FIFO and returns them
// to the host on addressed read strobes, with a block-ready flag on ok2[16].
module ok_pipe_out_fifo #(
  parameter logic [7:0]  ADDR        = 8'hA0,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  rst,
  input  logic [30:0]           ok1,
  output logic [16:0]           ok2,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FillMax  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] BlockLvl = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  logic [15:0]         mem_q [Depth];
  logic [15:0]         head_q;
  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] fill_q, fill_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                sel, rd, flush, pop, push, head_bypass;
  logic                unused_ok1;

  assign sel   = (ok1[23:16] == ADDR);
  assign rd    = sel & ok1[25];
  assign flush = rst | ok1[27];
  assign empty = (fill_q == '0);
  assign full  = (fill_q == FillMax);
  assign pop   = rd & ~empty;
  // A pop at full frees the slot the push lands in.
  assign push  = wr_en & (~full | pop);

  // With one word left, a simultaneous push lands exactly at the next head slot.
  assign head_bypass = push & pop & (wr_ptr_q == rd_ptr_d);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   fill_d = fill_q - (DEPTH_LOG2 + 1)'(1);
      default: fill_d = fill_q;
    endcase
    if (wr_en && !push) ovf_d = 1'b1;
    if (rd && empty)    unf_d = 1'b1;
  end

  always_ff @(posedge ti_clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage and head register need no reset; ok2 data is gated by empty.
  always_ff @(posedge ti_clk) begin
    if (!flush && push) mem_q[wr_ptr_q] <= wr_data;
    head_q <= head_bypass ? wr_data : mem_q[rd_ptr_d];
  end

  assign ok2       = {sel & (fill_q >= BlockLvl), pop ? head_q : 16'h0000};
  assign fill      = fill_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign unused_ok1 = ^{ok1[30:28], ok1[26:24], ok1[15:0]};

endmodule

// File: doc/ok_pipe_out_fifo.md
# ok_pipe_out_fifo

Device-side pipe-out endpoint sitting on the `ok1`/`ok2` bus from the host interface. It buffers 16-bit words produced by controller logic in a first-word-fall-through FIFO and returns them to the host on addressed read strobes. It also exports a block-ready flag for throttled block transfers. Multiple instances share `ok2` through an OR-combined bus.

## Interface

Parameters:
- `ADDR`, 8'hA0: endpoint address; legal range 8'hA0–8'hBF.
- `DEPTH_LOG2`, 10: FIFO depth is 2^DEPTH_LOG2 words.
- `BLOCK_WORDS`, 256: fill level at which `ok2[16]` (block ready) asserts; must be ≤ 2^DEPTH_LOG2.

Ports:
- `ti_clk`, in, 1: host-interface clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ok1`, in, 31: host bus.
  - [15:0] datain (unused here).
  - [23:16] addr.
  - [24] write.
  - [25] read.
  - [26] blockstrobe.
  - [27] ti_reset.
  - [30:28] reserved.
- `ok2`, out, 17: endpoint return bus.
  - [15:0] read data.
  - [16] block ready.
  - All zero when not selected.
- `wr_en`, in, 1: device-side push strobe.
- `wr_data`, in, 16: word to push.
- `fill`, out, DEPTH_LOG2+1: current word count.
- `full`, out, 1: fill == 2^DEPTH_LOG2.
- `empty`, out, 1: fill == 0.
- `overflow`, out, 1: sticky; a push was attempted while full.
- `underflow`, out, 1: sticky; a host read was attempted while empty.

## Operation

- **Select**: `sel = (ok1[23:16] == ADDR)`.
- **Host read**: `rd = sel & ok1[25]`.
- **Push**: `wr_en & ~full` writes `wr_data` at the write pointer and increments it.
- **Blocked push**: `wr_en & full` drops the word and sets `overflow`.
- **Pop**: `rd & ~empty` advances the read pointer. The next word is presented by the following cycle.
- **Underflow**: `rd & empty` leaves the pointers unchanged, returns 16'h0000, and sets `underflow`.
- **Simultaneous push and pop**:
  - Neither empty nor full: both occur and `fill` is unchanged.
  - Full: the pop frees a slot and the push is accepted; `overflow` is not set.
  - Empty: the push is accepted, the pop underflows, and the pushed word is not returned that cycle.
- **Pointers**: DEPTH_LOG2 bits, wrapping modulo depth. `fill` is a separate counter, so full and empty are never ambiguous.
- **`ok2[15:0]`**: equals the head word when `sel & ok1[25] & ~empty`; otherwise 0. This output is combinational from a registered head.
- **`ok2[16]`**: equals `sel & (fill >= BLOCK_WORDS)`.
- **Host reset**: `ok1[27]` (ti_reset) flushes the FIFO (pointers and fill to 0) and clears both sticky flags. It has the same effect as `rst`.
- **Write ignored**: `ok1[24]` is ignored; this is a read-only endpoint.
- **Blockstrobe**: `ok1[26]` has no effect on data. The host issues exactly BLOCK_WORDS reads after it.

## Timing

- **Reset values** (`rst` or ti_reset): `fill`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `ok2`=0.
- **Reset precedence**: `rst` asserted alongside push or pop wins; nothing is stored or popped.
- **Push-to-visible latency**: 2 cycles. A word pushed in cycle n into an empty FIFO is on `ok2[15:0]` under read in cycle n+2, and `empty` falls in cycle n+1.
- **Back-to-back reads**: reads every cycle return consecutive words with no bubbles; the head register is refilled from RAM each pop cycle.
- **Status updates**: `fill`, `full`, `empty` and `ok2[16]` are registered and update the cycle after the causing push or pop.
- **Sticky flags**: set the cycle after the offending event and held until reset.

## Test plan

- **Reset**: assert `rst` 3 cycles while pushing 0x1234. Expect `fill`=0, `empty`=1, and `ok2`=0 even with addr=ADDR and read=1.
- **Basic order**: push 0x0001..0x0004, then 4 reads at ADDR. Expect `ok2[15:0]` = 1, 2, 3, 4 on consecutive cycles. Then `empty`=1 and `underflow`=0.
- **Wrap and full** (DEPTH_LOG2=3): push 8 words. Expect `full`=1. A 9th push sets `overflow` and the word is dropped. Read 8 words: the original order comes back and the pointers wrap. Push and read 8 more and check the data.
- **Simultaneous at full**: with the FIFO full, push 0xBEEF in the same cycle as a read. Expect `fill` unchanged, `overflow`=0, and 0xBEEF read last.
- **Underflow and address decode**: a read at ADDR while empty returns 0 and sets `underflow`. A read at ADDR+1 while not empty gives `ok2`=0 and `fill` unchanged.
- **Block ready and host flush**: with BLOCK_WORDS=4, `ok2[16]` rises the cycle after the 4th push (when selected). A ti_reset pulse then gives `fill`=0, `ok2[16]`=0, and both sticky flags cleared.
